pwm_capture: RTL and testbench



---
 rtl/pwm_capture_pkg.sv | 19 +
 rtl/pwm_capture_div.sv | 78 +++++++
 rtl/pwm_capture.sv | 175 +++++++++++++++++
 tb/tb_pwm_capture.sv | 262 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/pwm_capture_pkg.sv
// pwm_capture_pkg: shared types and constants for the PWM capture block.
// FSM state enum, duty code width, divider iteration count, timeout helper.
package pwm_capture_pkg;

    typedef enum logic [1:0] {
        WAIT_RISE,
        HIGH,
        LOW
    } state_e;

    localparam int DUTY_W    = 8;
    localparam int DIV_ITERS = DUTY_W;

    // Largest count a cnt_w-bit counter may hold before a timeout result.
    function automatic longint unsigned timeout_cnt(input int unsigned cnt_w);
        return (64'd1 << cnt_w) - 64'd1;
    endfunction

endpackage

// File: rtl/pwm_capture_div.sv
// pwm_capture_div: restoring divider, quotient = floor(num*2^DUTY_W/den).
// Ports: clk, rst, start, num, den -> busy, done (1-cycle), quotient.
module pwm_capture_div
    import pwm_capture_pkg::*;
#(
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [CNT_W-1:0]  num,
    input  logic [CNT_W-1:0]  den,
    output logic              busy,
    output logic              done,
    output logic [DUTY_W-1:0] quotient
);

    localparam int IW = $clog2(DIV_ITERS);

    logic [CNT_W-1:0]  r_q;
    logic [CNT_W-1:0]  den_q;
    logic [DUTY_W-1:0] q_q;
    logic [IW-1:0]     it_q;
    logic              busy_q;
    logic              done_q;

    logic [CNT_W-1:0]  r_src;
    logic [CNT_W-1:0]  d_src;
    logic [CNT_W:0]    t;
    logic [CNT_W:0]    diff;
    logic              ge;
    logic [CNT_W-1:0]  r_nxt;

    // The load cycle already performs the first iteration, so the
    // quotient is complete after DIV_ITERS clock edges.
    always_comb begin
        r_src = busy_q ? r_q : num;
        d_src = busy_q ? den_q : den;
        t     = {r_src, 1'b0};
        diff  = t - {1'b0, d_src};
        ge    = (t >= {1'b0, d_src});
        // r < den always holds, so the new remainder fits CNT_W bits.
        r_nxt = ge ? diff[CNT_W-1:0] : t[CNT_W-1:0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_q    <= '0;
            den_q  <= '0;
            q_q    <= '0;
            it_q   <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (busy_q) begin
                r_q  <= r_nxt;
                q_q  <= {q_q[DUTY_W-2:0], ge};
                it_q <= it_q + IW'(1);
                if (it_q == IW'(DIV_ITERS - 1)) begin
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
            end else if (start) begin
                r_q    <= r_nxt;
                den_q  <= den;
                q_q    <= {{(DUTY_W-1){1'b0}}, ge};
                it_q   <= IW'(1);
                busy_q <= 1'b1;
            end
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign quotient = q_q;

endmodule

// File: rtl/pwm_capture.sv
// pwm_capture: measures high time and period of an async PWM input.
// Ports: clk, rst, en, pwm_in -> high_cnt, period_cnt, duty, valid, stuck, overrun.
module pwm_capture
    import pwm_capture_pkg::*;
#(
    parameter int CNT_W       = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              en,
    input  logic              pwm_in,
    output logic [CNT_W-1:0]  high_cnt,
    output logic [CNT_W-1:0]  period_cnt,
    output logic [DUTY_W-1:0] duty,
    output logic              valid,
    output logic              stuck,
    output logic              overrun
);

    localparam logic [CNT_W-1:0] TMAX = CNT_W'(timeout_cnt(CNT_W));
    localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

    logic [SYNC_STAGES-1:0] sync_q;
    logic                   s_d;
    logic                   s;
    logic                   rise;
    logic                   fall;

    state_e           state;
    logic [CNT_W-1:0] hcnt_q;
    logic [CNT_W-1:0] pcnt_q;
    logic [CNT_W-1:0] idle_q;
    logic [CNT_W-1:0] cap_h;
    logic [CNT_W-1:0] cap_p;
    logic             to_pend;
    logic             to_hi;

    logic              tmo;
    logic              cap;
    logic              div_start;
    logic              div_busy;
    logic              div_done;
    logic [DUTY_W-1:0] div_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q <= '0;
            s_d    <= 1'b0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], pwm_in};
            s_d    <= s;
        end
    end

    assign s    = sync_q[SYNC_STAGES-1];
    assign rise = s & ~s_d;
    assign fall = ~s & s_d;

    // WAIT_RISE has no period in progress, so it times out on idle_q.
    always_comb begin
        tmo = 1'b0;
        if (en) begin
            tmo = (state == WAIT_RISE) ? (idle_q == TMAX)
                                       : (pcnt_q == TMAX);
        end
    end

    assign cap       = en && (state == LOW) && rise && !tmo;
    assign div_start = cap && !div_busy;

    pwm_capture_div #(
        .CNT_W(CNT_W)
    ) u_div (
        .clk      (clk),
        .rst      (rst),
        .start    (div_start),
        .num      (hcnt_q),
        .den      (pcnt_q),
        .busy     (div_busy),
        .done     (div_done),
        .quotient (div_q)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= WAIT_RISE;
            hcnt_q     <= '0;
            pcnt_q     <= '0;
            idle_q     <= '0;
            cap_h      <= '0;
            cap_p      <= '0;
            to_pend    <= 1'b0;
            to_hi      <= 1'b0;
            high_cnt   <= '0;
            period_cnt <= '0;
            duty       <= '0;
            valid      <= 1'b0;
            stuck      <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            valid <= 1'b0;
            // A divider result wins; a pending timeout waits one cycle.
            if (div_done) begin
                high_cnt   <= cap_h;
                period_cnt <= cap_p;
                duty       <= div_q;
                stuck      <= 1'b0;
                valid      <= 1'b1;
            end else if (to_pend) begin
                to_pend    <= 1'b0;
                high_cnt   <= to_hi ? TMAX : '0;
                period_cnt <= TMAX;
                duty       <= to_hi ? '1 : '0;
                stuck      <= 1'b1;
                valid      <= 1'b1;
            end

            if (div_start) begin
                cap_h <= hcnt_q;
                cap_p <= pcnt_q;
            end
            if (cap && div_busy) begin
                overrun <= 1'b1;
            end

            if (!en) begin
                state  <= WAIT_RISE;
                hcnt_q <= '0;
                pcnt_q <= '0;
                idle_q <= '0;
            end else if (tmo) begin
                to_pend <= 1'b1;
                to_hi   <= s;
                state   <= WAIT_RISE;
                hcnt_q  <= '0;
                pcnt_q  <= '0;
                idle_q  <= '0;
            end else begin
                unique case (state)
                    WAIT_RISE: begin
                        if (rise) begin
                            hcnt_q <= ONE;
                            pcnt_q <= ONE;
                            idle_q <= '0;
                            state  <= HIGH;
                        end else begin
                            idle_q <= idle_q + ONE;
                        end
                    end
                    HIGH: begin
                        pcnt_q <= pcnt_q + ONE;
                        if (fall) begin
                            state <= LOW;
                        end else begin
                            hcnt_q <= hcnt_q + ONE;
                        end
                    end
                    LOW: begin
                        // The rise cycle belongs to the next period.
                        if (rise) begin
                            hcnt_q <= ONE;
                            pcnt_q <= ONE;
                            state  <= HIGH;
                        end else begin
                            pcnt_q <= pcnt_q + ONE;
                        end
                    end
                    default: state <= WAIT_RISE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pwm_capture.sv
// tb_pwm_capture: scoreboard bench for pwm_capture.
// Expected results are queued with the stimulus and popped on each valid.
module tb_pwm_capture;

    localparam int CW  = 10;
    localparam int SS  = 2;
    localparam int TMX = (1 << CW) - 1;

    typedef struct {
        int h;
        int p;
        int d;
        int st;
    } res_t;

    logic          clk;
    logic          rst;
    logic          en;
    logic          pwm_in;
    logic [CW-1:0] high_cnt;
    logic [CW-1:0] period_cnt;
    logic [7:0]    duty;
    logic          valid;
    logic          stuck;
    logic          overrun;

    res_t sb[$];
    int   vstamp[$];
    res_t mon_r;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc   = 0;
    int   t0;

    pwm_capture #(
        .CNT_W(CW),
        .SYNC_STAGES(SS)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .en         (en),
        .pwm_in     (pwm_in),
        .high_cnt   (high_cnt),
        .period_cnt (period_cnt),
        .duty       (duty),
        .valid      (valid),
        .stuck      (stuck),
        .overrun    (overrun)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic expect_eq(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d want %0d", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (valid === 1'b1) begin
            vstamp.push_back(cyc);
            expect_eq("sb_pending", int'(sb.size() != 0), 1);
            if (sb.size() != 0) begin
                mon_r = sb.pop_front();
                expect_eq("high_cnt", int'(high_cnt), mon_r.h);
                expect_eq("period_cnt", int'(period_cnt), mon_r.p);
                expect_eq("duty", int'(duty), mon_r.d);
                expect_eq("stuck", int'(stuck), mon_r.st);
            end
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic push(input int h, input int p, input int d, input int st);
        res_t r;
        r.h  = h;
        r.p  = p;
        r.d  = d;
        r.st = st;
        sb.push_back(r);
    endtask

    task automatic gen(input int d, input int n);
        for (int i = 0; i < n; i++) begin
            pwm_in = 1'b1;
            tick(d);
            pwm_in = 1'b0;
            tick(256 - d);
        end
    endtask

    task automatic drain(input int bound);
        int k;
        k = 0;
        while (sb.size() != 0 && k < bound) begin
            tick(1);
            k++;
        end
        expect_eq("drain", sb.size(), 0);
    endtask

    task automatic do_reset;
        rst    = 1'b1;
        en     = 1'b0;
        pwm_in = 1'b0;
        tick(3);
        rst = 1'b0;
        tick(1);
    endtask

    task automatic check_zero(input string tag);
        expect_eq({tag, "_high"}, int'(high_cnt), 0);
        expect_eq({tag, "_period"}, int'(period_cnt), 0);
        expect_eq({tag, "_duty"}, int'(duty), 0);
        expect_eq({tag, "_valid"}, int'(valid), 0);
        expect_eq({tag, "_stuck"}, int'(stuck), 0);
        expect_eq({tag, "_overrun"}, int'(overrun), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst    = 1'b1;
        en     = 1'b0;
        pwm_in = 1'b0;
        do_reset();
        check_zero("rst");

        // 50% duty, period 256, gapless periods.
        en = 1'b1;
        vstamp.delete();
        for (int i = 0; i < 3; i++) push(128, 256, 128, 0);
        gen(128, 4);
        drain(40);
        tick(12);
        expect_eq("n128", vstamp.size(), 3);
        for (int i = 1; i < vstamp.size(); i++)
            expect_eq("gap128", vstamp[i] - vstamp[i-1], 256);
        en = 1'b0;

        // Extreme duties.
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 2; i++) push(1, 256, 1, 0);
        gen(1, 3);
        drain(40);
        en = 1'b0;
        do_reset();
        en = 1'b1;
        for (int i = 0; i < 2; i++) push(254, 256, 254, 0);
        gen(254, 3);
        drain(40);
        en = 1'b0;

        // 3-cycle periods: faster than the divider, so overrun.
        do_reset();
        en = 1'b1;
        vstamp.delete();
        t0 = 0;
        push(2, 3, 170, 0);
        for (int i = 0; i < 4; i++) begin
            pwm_in = 1'b1;
            if (i == 1) t0 = cyc;
            tick(2);
            pwm_in = 1'b0;
            tick(1);
        end
        drain(30);
        tick(12);
        expect_eq("n3cyc", vstamp.size(), 1);
        if (vstamp.size() > 0)
            expect_eq("lat3cyc", vstamp[0] - t0, SS + 9);
        expect_eq("overrun", int'(overrun), 1);
        en = 1'b0;

        // Stuck low, then stuck high, then a normal period clears stuck.
        do_reset();
        push(0, TMX, 0, 1);
        en = 1'b1;
        drain(TMX + 50);
        expect_eq("stuck_hold", int'(stuck), 1);
        en = 1'b0;
        do_reset();
        push(TMX, TMX, 255, 1);
        en     = 1'b1;
        pwm_in = 1'b1;
        drain(TMX + 50);
        pwm_in = 1'b0;
        tick(5);
        push(64, 256, 64, 0);
        gen(64, 2);
        drain(40);
        expect_eq("stuck_clr", int'(stuck), 0);
        en = 1'b0;

        // Reset in the middle of a divide discards that result.
        do_reset();
        en = 1'b1;
        push(2, 3, 170, 0);
        for (int i = 0; i < 2; i++) begin
            pwm_in = 1'b1;
            tick(2);
            pwm_in = 1'b0;
            tick(1);
        end
        drain(30);
        pwm_in = 1'b1;
        tick(2);
        pwm_in = 1'b0;
        tick(5);
        rst = 1'b1;
        tick(1);
        check_zero("midrst");
        rst = 1'b0;
        tick(20);
        push(2, 3, 170, 0);
        for (int i = 0; i < 2; i++) begin
            pwm_in = 1'b1;
            tick(2);
            pwm_in = 1'b0;
            tick(1);
        end
        drain(30);
        tick(12);
        en = 1'b0;

        // en dropped mid-HIGH aborts that period.
        do_reset();
        en     = 1'b1;
        pwm_in = 1'b1;
        tick(20);
        en = 1'b0;
        tick(40);
        pwm_in = 1'b0;
        tick(5);
        en = 1'b1;
        tick(5);
        for (int i = 0; i < 2; i++) push(100, 256, 100, 0);
        gen(100, 3);
        drain(40);
        tick(12);
        en = 1'b0;

        expect_eq("sb_empty", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
